// File: rtl/console_pkg.sv
// Shared constants and state codes for the console character feeder.
// The char_ok() helper is the single source of the printable filter.
package console_pkg;

  localparam logic [6:0] CR    = 7'h0D;
  localparam logic [6:0] LF    = 7'h0A;
  localparam logic [6:0] BS    = 7'h08;
  localparam logic [6:0] TAB   = 7'h09;
  localparam logic [6:0] SPACE = 7'h20;
  localparam logic [6:0] TILDE = 7'h7E;

  localparam int unsigned COLS_DEF     = 30;
  localparam int unsigned HOME_COL_DEF = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_TAB   = 3'd4;

  function automatic logic char_ok(
    input logic [6:0] c,
    input logic       tab_en
  );
    return (c >= SPACE && c <= TILDE) ||
           c == CR || c == LF || c == BS ||
           (tab_en && c == TAB);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-2 depth, registered occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = cnt_q == (AW+1)'(DEPTH);
  assign empty    = cnt_q == '0;
  assign count    = cnt_q;
  assign pop_data = mem_q[rp_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) wp_d = wp_q + AW'(1);
    if (do_pop)  rp_d = rp_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/console_char_feeder.sv
// Feeds filtered characters to the console, pacing around scroll.
// Define CONSOLE_FEEDER_TAB_EXPAND_EN to expand TAB into spaces locally.
module console_char_feeder
  import console_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned COLS     = COLS_DEF,
  parameter int unsigned HOME_COL = HOME_COL_DEF,
  parameter int unsigned TAB_W    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_data,
  output logic                   wr_ready,
  input  logic                   scroll,
  output logic                   font_we,
  output logic [7:0]             font_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int unsigned MW = $clog2(COLS);
  localparam logic [MW-1:0] LastCol = MW'(COLS - 1);
  localparam logic [MW-1:0] HomeCol = MW'(HOME_COL);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      TAB_W < 1 || (TAB_W & (TAB_W - 1)) != 0) begin : g_bad_cfg
    $error("console_char_feeder: DEPTH/TAB_W must be powers of 2");
  end

  logic [2:0]    state_q, state_d;
  logic [6:0]    char_q, char_d;
  logic [MW-1:0] col_q, col_d;
  logic [MW-1:0] col_nxt;
  logic [6:0]    head;
  logic          full, empty, pop;
  logic          tab_pend;
  logic          unused_msb;

  assign unused_msb = wr_data[7];

`ifdef CONSOLE_FEEDER_TAB_EXPAND_EN
  localparam logic TabEn = 1'b1;
  localparam int unsigned CW = $clog2(TAB_W) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tab_pend = cnt_q != '0;
`else
  localparam logic TabEn = 1'b0;
  assign tab_pend = 1'b0;
`endif

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(7)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_valid),
    .push_data(wr_data[6:0]),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  // Cursor prediction for the character currently being issued
  always_comb begin
    if (char_q == CR || char_q == LF || col_q == LastCol)
      col_nxt = HomeCol;
    else if (char_q == BS)
      col_nxt = (col_q == '0) ? col_q : col_q - MW'(1);
    else
      col_nxt = col_q + MW'(1);
  end

  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    col_d   = col_q;
    pop     = 1'b0;
`ifdef CONSOLE_FEEDER_TAB_EXPAND_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!empty && !scroll) begin
          pop    = 1'b1;
          char_d = head;
          if (char_ok(head, TabEn)) begin
            state_d = ST_ISSUE;
`ifdef CONSOLE_FEEDER_TAB_EXPAND_EN
            if (head == TAB) begin
              state_d = ST_TAB;
              cnt_d   = CW'(TAB_W - (32'(col_q) % TAB_W));
            end
`endif
          end
        end
      end
      ST_ISSUE: begin
        col_d   = col_nxt;
        state_d = ST_GAP;
`ifdef CONSOLE_FEEDER_TAB_EXPAND_EN
        if (cnt_q != '0)
          cnt_d = (col_q == LastCol) ? '0 : cnt_q - CW'(1);
`endif
      end
      ST_GAP, ST_HOLD: begin
        if (scroll)        state_d = ST_HOLD;
        else if (tab_pend) state_d = ST_TAB;
        else               state_d = ST_IDLE;
      end
`ifdef CONSOLE_FEEDER_TAB_EXPAND_EN
      ST_TAB: begin
        char_d  = SPACE;
        state_d = ST_ISSUE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      char_q  <= '0;
      col_q   <= '0;
`ifdef CONSOLE_FEEDER_TAB_EXPAND_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      col_q   <= col_d;
`ifdef CONSOLE_FEEDER_TAB_EXPAND_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign wr_ready  = !full;
  assign font_we   = state_q == ST_ISSUE;
  assign font_data = font_we ? {1'b0, char_q} : 8'h00;
  assign busy      = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_console_char_feeder.sv
// Self-checking bench for console_char_feeder: vector table,
// hand-timed corner sequences and a random run against a stream model.
module tb_console_char_feeder;

  localparam int DEPTH    = 16;
  localparam int COLS     = 30;
  localparam int HOME_COL = 2;
  localparam int TAB_W    = 4;
  localparam int CW       = $clog2(DEPTH) + 1;
`ifdef CONSOLE_FEEDER_TAB_EXPAND_EN
  localparam bit TAB_EN = 1'b1;
`else
  localparam bit TAB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          scroll = 1'b0;
  logic          wr_ready, font_we, busy;
  logic [7:0]    font_data;
  logic [CW-1:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_st  = -100;
  int col_m    = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] din;
    int         n;
    logic [7:0] dout;
  } vec_t;
  vec_t vt[12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  console_char_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .scroll    (scroll),
    .font_we   (font_we),
    .font_data (font_data),
    .fifo_count(fifo_count),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: which characters reach the console, and where the cursor goes
  function automatic bit ok_char(input logic [6:0] c);
    return (c >= 7'h20 && c <= 7'h7E) || c == 7'h0D ||
           c == 7'h0A || c == 7'h08 || (TAB_EN && c == 7'h09);
  endfunction

  function automatic void adv(input logic [6:0] c);
    if (c == 7'h0D || c == 7'h0A || col_m == COLS - 1) col_m = HOME_COL;
    else if (c == 7'h08) col_m = (col_m == 0) ? 0 : col_m - 1;
    else col_m = col_m + 1;
  endfunction

  function automatic void model_feed(input logic [7:0] b);
    logic [6:0] c;
    int n;
    bit wrap;
    c = b[6:0];
    if (!ok_char(c)) return;
    if (c == 7'h09) begin
      n = TAB_W - (col_m % TAB_W);
      for (int i = 0; i < n; i++) begin
        wrap = (col_m == COLS - 1);
        exp_q.push_back(8'h20);
        adv(7'h20);
        if (wrap) break;
      end
    end else begin
      exp_q.push_back({1'b0, c});
      adv(c);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && font_we === 1'b1) begin
      chk("strobe_spacing", 32'(cyc - last_st >= 2), 1);
      chk("strobe_bit7", 32'(font_data[7]), 0);
      got_q.push_back(font_data);
      last_st = cyc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    wr_valid = 1'b0;
    scroll = 1'b0;
    #1;
    chk("rst_font_we", 32'(font_we), 0);
    chk("rst_font_data", 32'(font_data), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    col_m = 0;
  endtask

  // Must be called at a negedge; returns at the following negedge
  task automatic push1(input logic [7:0] c, output bit acc);
    acc = wr_ready;
    wr_valid = 1'b1;
    wr_data = c;
    @(negedge clk);
    wr_valid = 1'b0;
    if (acc) model_feed(c);
  endtask

  task automatic push_wait(input logic [7:0] c);
    bit acc;
    int i;
    for (i = 0; i < 200; i++) begin
      push1(c, acc);
      if (acc) break;
    end
    chk("push_wait_accepted", 32'(acc), 1);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(nm, 32'(busy), 0);
  endtask

  task automatic wait_strobe(input string nm);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (font_we) break;
    end
    chk(nm, 32'(font_we), 1);
  endtask

  task automatic cmp_streams(input string nm);
    chk({nm, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({nm, "_chr"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [7:0] rnd_byte();
    int r;
    logic [7:0] ctl[4];
    ctl[0] = 8'h0D; ctl[1] = 8'h0A; ctl[2] = 8'h08; ctl[3] = 8'h09;
    r = $urandom_range(0, 9);
    if (r == 0) return ctl[$urandom_range(0, 3)];
    if (r == 1) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(32, 126));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int s;

    vt[0]  = '{8'h41, 1, 8'h41};
    vt[1]  = '{8'h07, 0, 8'h00};
    vt[2]  = '{8'h7F, 0, 8'h00};
    vt[3]  = '{8'hC1, 1, 8'h41};
    vt[4]  = '{8'h20, 1, 8'h20};
    vt[5]  = '{8'h7E, 1, 8'h7E};
    vt[6]  = '{8'h1F, 0, 8'h00};
    vt[7]  = '{8'h0D, 1, 8'h0D};
    vt[8]  = '{8'h0A, 1, 8'h0A};
    vt[9]  = '{8'h08, 1, 8'h08};
    vt[10] = '{8'h09, TAB_EN ? 4 : 0, 8'h20};
    vt[11] = '{8'h80, 0, 8'h00};

    for (int v = 0; v < 12; v++) begin
      do_reset();
      push1(vt[v].din, acc);
      wait_idle("vec_idle");
      chk($sformatf("vec%0d_count", v), got_q.size(), vt[v].n);
      if (got_q.size() > 0)
        chk($sformatf("vec%0d_data", v), got_q[0], vt[v].dout);
      cmp_streams("vec_model");
    end

    // "AB": pop, ISSUE, GAP, IDLE, pop, ISSUE ...
    do_reset();
    push1(8'h41, acc);
    push1(8'h42, acc);
    chk("ab_we_a", 32'(font_we), 1);
    chk("ab_data_a", 32'(font_data), 32'h41);
    @(negedge clk); chk("ab_gap1", 32'(font_we), 0);
    @(negedge clk); chk("ab_gap2", 32'(font_we), 0);
    @(negedge clk);
    chk("ab_we_b", 32'(font_we), 1);
    chk("ab_data_b", 32'(font_data), 32'h42);
    @(negedge clk);
    chk("ab_gap_b", 32'(font_we), 0);
    chk("ab_busy_gap", 32'(busy), 1);
    @(negedge clk); chk("ab_busy_drop", 32'(busy), 0);
    cmp_streams("ab");

    // Fill the FIFO while parked in HOLD
    do_reset();
    push1(8'h58, acc);
    wait_strobe("fill_first_strobe");
    scroll = 1'b1;
    for (int i = 0; i < 16; i++) push1(8'h61 + 8'(i), acc);
    chk("fill_count16", 32'(fifo_count), 16);
    chk("fill_ready_low", 32'(wr_ready), 0);
    push1(8'h5A, acc);
    chk("fill_count_held", 32'(fifo_count), 16);
    repeat (10) @(negedge clk);
    chk("fill_no_strobe_hold", got_q.size(), 1);
    scroll = 1'b0;
    wait_idle("fill_idle");
    cmp_streams("fill");

    // LF, then a long scroll beginning in GAP
    do_reset();
    push1(8'h0A, acc);
    wait_strobe("lf_strobe");
    scroll = 1'b1;
    push1(8'h5A, acc);
    s = 0;
    repeat (119) begin
      @(negedge clk);
      if (font_we) s++;
    end
    chk("hold_no_strobe", s, 0);
    chk("hold_count", 32'(fifo_count), 1);
    scroll = 1'b0;
    @(negedge clk); chk("release_we0", 32'(font_we), 0);
    @(negedge clk);
    chk("release_we1", 32'(font_we), 1);
    chk("release_data", 32'(font_data), 32'h5A);
    wait_idle("release_idle");
    cmp_streams("scroll");

    // Scroll in IDLE blocks popping; then reset during ISSUE
    do_reset();
    scroll = 1'b1;
    for (int i = 0; i < 6; i++) push1(8'h31 + 8'(i), acc);
    repeat (3) @(negedge clk);
    chk("idle_scroll_count", 32'(fifo_count), 6);
    chk("idle_scroll_nostrobe", got_q.size(), 0);
    scroll = 1'b0;
    @(negedge clk);
    chk("mid_issue_we", 32'(font_we), 1);
    chk("mid_issue_count", 32'(fifo_count), 5);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(font_we), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_ready", 32'(wr_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    col_m = 0;

`ifdef CONSOLE_FEEDER_TAB_EXPAND_EN
    do_reset();
    for (int i = 0; i < 5; i++) push1(8'h61 + 8'(i), acc);
    push1(8'h09, acc);
    wait_idle("tab5_idle");
    chk("tab5_len", got_q.size(), 8);
    cmp_streams("tab5");
    push1(8'h09, acc);
    wait_idle("tab8_idle");
    chk("tab8_len", got_q.size(), 4);
    cmp_streams("tab8");
    do_reset();
    for (int i = 0; i < 28; i++) push_wait(8'h78);
    push_wait(8'h09);
    wait_idle("tab28_idle");
    chk("tab28_len", got_q.size(), 30);
    cmp_streams("tab28");
    push1(8'h09, acc);
    wait_idle("tabhome_idle");
    chk("tabhome_len", got_q.size(), 2);
    cmp_streams("tabhome");
`endif

    // Random traffic with random scroll bursts
    do_reset();
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 19) == 0) scroll = ~scroll;
      if ($urandom_range(0, 99) < 60) push1(rnd_byte(), acc);
      else @(negedge clk);
    end
    scroll = 1'b0;
    wait_idle("rand_idle");
    chk("rand_count_end", 32'(fifo_count), 0);
    cmp_streams("rand");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
